// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, finds the start bit, samples each bit at its centre
// on the oversampled tick, and holds the byte with ready/overrun/frame-error flags for the host.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       rx,
  input  logic       tick,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int TC_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TC_W-1:0] TC_MID  = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [TC_W-1:0]   tc_reg, tc_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        data_out_reg, data_out_next;
  logic              data_ready_reg, data_ready_next;
  logic              frame_err_reg, frame_err_next;
  logic              overrun_reg, overrun_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic              rxs;
  logic              byte_done;
  logic              frame_hit;

  // Flops preset high so a reset never looks like a start bit.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
    end
  end

  assign rxs = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      tc_reg         <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      data_out_reg   <= '0;
      data_ready_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      tc_reg         <= tc_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      data_out_reg   <= data_out_next;
      data_ready_reg <= data_ready_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tc_next       = tc_reg;
    bit_next      = bit_reg;
    shift_next    = shift_reg;
    data_out_next = data_out_reg;
    byte_done     = 1'b0;
    frame_hit     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          tc_next    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tc_reg == TC_MID) begin
            tc_next = '0;
            if (rxs) begin
              state_next = IDLE;
            end else begin
              state_next = DATA;
              bit_next   = '0;
            end
          end else begin
            tc_next = tc_reg + TC_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tc_reg == TC_LAST) begin
            tc_next    = '0;
            shift_next = {rxs, shift_reg[7:1]};
            if (bit_reg == 3'd7) begin
              state_next = STOP;
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end else begin
            tc_next = tc_reg + TC_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tc_reg == TC_LAST) begin
            tc_next = '0;
            if (rxs) begin
              byte_done     = 1'b1;
              data_out_next = shift_reg;
              state_next    = IDLE;
            end else begin
              frame_hit  = 1'b1;
              state_next = WAIT_HIGH;
            end
          end else begin
            tc_next = tc_reg + TC_W'(1);
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A completing byte takes priority over a same-cycle read; a read in that cycle
  // only suppresses the overrun and clears the stale frame error.
  always_comb begin
    data_ready_next = data_ready_reg;
    overrun_next    = overrun_reg;
    frame_err_next  = frame_err_reg;

    if (byte_done) begin
      data_ready_next = 1'b1;
      if (rd_en) begin
        overrun_next   = 1'b0;
        frame_err_next = 1'b0;
      end else begin
        overrun_next = overrun_reg | data_ready_reg;
      end
    end else if (frame_hit) begin
      frame_err_next = 1'b1;
      if (rd_en) begin
        data_ready_next = 1'b0;
        overrun_next    = 1'b0;
      end
    end else if (rd_en) begin
      data_ready_next = 1'b0;
      overrun_next    = 1'b0;
      frame_err_next  = 1'b0;
    end
  end

  assign data_out   = data_out_reg;
  assign data_ready = data_ready_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign rx_busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 16x oversampling, tick every 4 clocks, 64-clock bit period.
module tb_uart_rx;

  logic       Clock;
  logic       Reset_n;
  logic       rx;
  logic       tick;
  logic       rd_en;
  logic [7:0] data_out;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int tick_seen = 0;
  logic [1:0] tdiv = 2'd0;

  localparam int BIT_CLKS   = 64;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;
  localparam int STOP_TICK  = 8 + 8 * 16 + 16;

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .rx         (rx),
    .tick       (tick),
    .rd_en      (rd_en),
    .data_out   (data_out),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial tick = 1'b0;
  always @(negedge Clock) begin
    tdiv = tdiv + 2'd1;
    tick = (tdiv == 2'd0);
  end

  // Drives frame steps [from,to) one clock each, rx updated just after the falling edge.
  // Step 0 starts the start bit; the DUT sees it two edges later and counts ticks from
  // edge 4 onward, so tick number STOP_TICK is the stop-sample cycle.
  task automatic drive_steps(input logic [7:0] d, input logic stop, input int from,
                             input int to, input int rd_tick);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (from == 0) tick_seen = 0;
    for (int s = from; s < to; s++) begin
      @(negedge Clock);
      #1;
      rx = bits[s / BIT_CLKS];
      rd_en = 1'b0;
      if ((s + 1) >= 4 && tick) begin
        tick_seen++;
        if (rd_tick != 0 && tick_seen == rd_tick) rd_en = 1'b1;
      end
    end
    @(negedge Clock);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_tick);
    drive_steps(d, stop, 0, FRAME_CLKS, rd_tick);
    $display("frame 0x%02h stop=%0d: data_out=0x%02h ready=%0d ferr=%0d ovr=%0d busy=%0d",
             d, stop, data_out, data_ready, frame_err, overrun, rx_busy);
  endtask

  task automatic pulse_rd();
    @(negedge Clock);
    #1 rd_en = 1'b1;
    @(negedge Clock);
    #1 rd_en = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    rx = 1'b1;
    rd_en = 1'b0;
    idle_clks(3);
    Reset_n = 1'b1;
    idle_clks(3);
    total_cnt++;
    if (data_out !== 8'h00) $display("FAIL reset_data_out: got %h expected 00", data_out);
    else pass_cnt++;
    total_cnt++;
    if ({data_ready, frame_err, overrun, rx_busy} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {data_ready, frame_err, overrun, rx_busy});
    else pass_cnt++;
  endtask

  task automatic test_receive();
    drive_steps(8'hA5, 1'b1, 0, 300, 0);
    total_cnt++;
    if (rx_busy !== 1'b1) $display("FAIL a5_busy_mid: got %b expected 1", rx_busy);
    else pass_cnt++;
    drive_steps(8'hA5, 1'b1, 300, FRAME_CLKS, 0);
    $display("frame 0xa5: data_out=0x%02h ready=%0d", data_out, data_ready);
    total_cnt++;
    if (data_out !== 8'hA5) $display("FAIL a5_data: got %h expected a5", data_out);
    else pass_cnt++;
    total_cnt++;
    if ({data_ready, frame_err, overrun, rx_busy} !== 4'b1000)
      $display("FAIL a5_flags: got %b expected 1000", {data_ready, frame_err, overrun, rx_busy});
    else pass_cnt++;
    pulse_rd();
    total_cnt++;
    if (data_ready !== 1'b0) $display("FAIL rd_clears_ready: got %b expected 0", data_ready);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    idle_clks(6);
    total_cnt++;
    if (rx_busy !== 1'b1) $display("FAIL glitch_busy: got %b expected 1", rx_busy);
    else pass_cnt++;
    idle_clks(6);
    rx = 1'b1;
    idle_clks(60);
    $display("glitch: busy=%0d ready=%0d", rx_busy, data_ready);
    total_cnt++;
    if ({rx_busy, data_ready, frame_err} !== 3'b000)
      $display("FAIL glitch_idle: got %b expected 000", {rx_busy, data_ready, frame_err});
    else pass_cnt++;
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 0);
    idle_clks(200);
    total_cnt++;
    if ({frame_err, data_ready, rx_busy} !== 3'b101)
      $display("FAIL break_flags: got %b expected 101", {frame_err, data_ready, rx_busy});
    else pass_cnt++;
    total_cnt++;
    if (data_out !== 8'hA5) $display("FAIL break_data_kept: got %h expected a5", data_out);
    else pass_cnt++;
    rx = 1'b1;
    idle_clks(5);
    total_cnt++;
    if (rx_busy !== 1'b0) $display("FAIL break_release: got %b expected 0", rx_busy);
    else pass_cnt++;
    send_frame(8'h5A, 1'b1, 0);
    total_cnt++;
    if (data_out !== 8'h5A) $display("FAIL after_break_data: got %h expected 5a", data_out);
    else pass_cnt++;
    total_cnt++;
    if ({data_ready, frame_err} !== 2'b11)
      $display("FAIL after_break_flags: got %b expected 11", {data_ready, frame_err});
    else pass_cnt++;
    pulse_rd();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 0);
    total_cnt++;
    if (data_out !== 8'h22) $display("FAIL b2b_data: got %h expected 22", data_out);
    else pass_cnt++;
    total_cnt++;
    if ({data_ready, overrun, frame_err} !== 3'b110)
      $display("FAIL b2b_flags: got %b expected 110", {data_ready, overrun, frame_err});
    else pass_cnt++;
    pulse_rd();
    total_cnt++;
    if ({data_ready, overrun, frame_err} !== 3'b000)
      $display("FAIL b2b_rd_clear: got %b expected 000", {data_ready, overrun, frame_err});
    else pass_cnt++;
  endtask

  task automatic test_rd_same_cycle();
    send_frame(8'h81, 1'b1, 0);
    total_cnt++;
    if ({data_out, data_ready} !== {8'h81, 1'b1})
      $display("FAIL first_81: got %h/%b expected 81/1", data_out, data_ready);
    else pass_cnt++;
    send_frame(8'h7E, 1'b1, STOP_TICK);
    total_cnt++;
    if (data_out !== 8'h7E) $display("FAIL rdsame_data: got %h expected 7e", data_out);
    else pass_cnt++;
    total_cnt++;
    if ({data_ready, overrun} !== 2'b10)
      $display("FAIL rdsame_flags: got %b expected 10", {data_ready, overrun});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive_steps(8'hFF, 1'b1, 0, 5 * BIT_CLKS + 32, 0);
    Reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({data_out, data_ready, frame_err, overrun, rx_busy} !== 12'h000)
      $display("FAIL midreset_async: got %h/%b expected 00/0000", data_out,
               {data_ready, frame_err, overrun, rx_busy});
    else pass_cnt++;
    rx = 1'b1;
    idle_clks(3);
    Reset_n = 1'b1;
    idle_clks(BIT_CLKS * 4);
    total_cnt++;
    if ({data_ready, rx_busy} !== 2'b00)
      $display("FAIL midreset_idle: got %b expected 00", {data_ready, rx_busy});
    else pass_cnt++;
    send_frame(8'h00, 1'b1, 0);
    total_cnt++;
    if ({data_out, data_ready, frame_err} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL after_reset_00: got %h/%b%b expected 00/10", data_out, data_ready, frame_err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_receive();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_rd_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
